// File: rtl/branch_resolve_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_if
//   Bundles the fetch-side push channel, the execute-side resolve channel and
//   every result/status output of branch_resolve.
//   master : the fetch/execute environment. It drives push_* and resolve_* and
//            observes the redirect, training, status and statistics outputs.
//   slave  : branch_resolve itself.
// ---------------------------------------------------------------------------
interface branch_resolve_if;
    // push channel (fetch)
    logic        push;
    logic        push_is_jal;
    logic        push_predict;
    logic [31:0] push_target;
    logic [31:0] push_fallthrough;
    // resolve channel (execute)
    logic        resolve;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    // queue status
    logic        full;
    logic        empty;
    // redirect and predictor training
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        train_branch;
    logic        train_result;
    // sticky error flags and statistics
    logic        overflow;
    logic        underflow;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output push, push_is_jal, push_predict, push_target, push_fallthrough,
        output resolve, resolve_taken, resolve_target,
        input  full, empty, redirect, redirect_pc, train_branch, train_result,
        input  overflow, underflow, stat_branches, stat_mispredicts
    );

    modport slave (
        input  push, push_is_jal, push_predict, push_target, push_fallthrough,
        input  resolve, resolve_taken, resolve_target,
        output full, empty, redirect, redirect_pc, train_branch, train_result,
        output overflow, underflow, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//   In-order queue of branch/JAL predictions between fetch and execute.
//   Fetch pushes each prediction. Execute resolves the oldest one. On a
//   wrong prediction the block pulses redirect with the corrected PC and
//   flushes every younger (wrong-path) entry. Conditional branches produce a
//   training pulse for the predictor. Hit/mispredict statistics are kept.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : branch_resolve_if.slave carrying push, resolve, redirect, training,
//          status and statistics signals
// ---------------------------------------------------------------------------
module branch_resolve #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolve_if.slave  bus
);

    typedef struct packed {
        logic        is_jal;
        logic        predict;
        logic [31:0] target;
        logic [31:0] fallthrough;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic        full;
    logic        empty;
    logic        do_pop;
    logic        do_push;
    logic        mispredict;
    logic        trains;
    logic [31:0] correct_pc;
    entry_t      head;
    entry_t      new_entry;

    logic        redirect_q;
    logic [31:0] redirect_pc_q;
    logic        train_branch_q;
    logic        train_result_q;
    logic        overflow_q;
    logic        underflow_q;
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    assign head      = mem[rd_ptr];
    assign new_entry = '{is_jal:      bus.push_is_jal,
                         predict:     bus.push_predict,
                         target:      bus.push_target,
                         fallthrough: bus.push_fallthrough};

    // Resolve / mispredict decode on the head entry.
    always_comb begin
        do_pop     = bus.resolve && !empty;
        mispredict = 1'b0;
        trains     = 1'b0;
        correct_pc = bus.resolve_taken ? bus.resolve_target : head.fallthrough;
        if (do_pop) begin
            trains     = !head.is_jal;
            mispredict = (head.predict != bus.resolve_taken) ||
                         (head.predict && bus.resolve_taken &&
                          (head.target != bus.resolve_target));
        end
        // A pop frees a slot this cycle, so a full queue still accepts the
        // push. A mispredict makes any same-cycle push wrong-path.
        do_push = bus.push && (!full || do_pop) && !mispredict;
    end

    // NOTE: the entry storage has no reset; pointers and count define which
    // slots are valid, so clearing the array would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_q         <= 1'b0;
            redirect_pc_q      <= '0;
            train_branch_q     <= 1'b0;
            train_result_q     <= 1'b0;
            overflow_q         <= 1'b0;
            underflow_q        <= 1'b0;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            redirect_q     <= mispredict;
            train_branch_q <= trains;
            if (mispredict) begin
                redirect_pc_q      <= correct_pc;
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
            if (trains) begin
                train_result_q  <= bus.resolve_taken;
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            // A push dropped as wrong-path is not an overflow.
            if (bus.push && full && !do_pop) overflow_q <= 1'b1;
            if (bus.resolve && empty)        underflow_q <= 1'b1;
        end
    end

    assign bus.full             = full;
    assign bus.empty            = empty;
    assign bus.redirect         = redirect_q;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.train_branch     = train_branch_q;
    assign bus.train_result     = train_result_q;
    assign bus.overflow         = overflow_q;
    assign bus.underflow        = underflow_q;
    assign bus.stat_branches    = stat_branches_q;
    assign bus.stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve
//   Directed and random stimulus for branch_resolve, checked every cycle
//   against a queue-based reference model of prediction resolution.
// ---------------------------------------------------------------------------
module tb_branch_resolve;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    branch_resolve_if bif();

    branch_resolve #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_jal;
        bit          predict;
        logic [31:0] target;
        logic [31:0] ft;
    } pred_t;

    pred_t       q[$];
    int          checks   = 0;
    int          failures = 0;

    logic        e_redirect;
    logic [31:0] e_rpc;
    logic        e_tb;
    logic        e_tr;
    logic        e_ovf;
    logic        e_unf;
    logic [31:0] e_br;
    logic [31:0] e_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        e_redirect = 1'b0;
        e_rpc      = '0;
        e_tb       = 1'b0;
        e_tr       = 1'b0;
        e_ovf      = 1'b0;
        e_unf      = 1'b0;
        e_br       = '0;
        e_mis      = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".full"},        bif.full,         (q.size() == DEPTH));
        check({tag, ".empty"},       bif.empty,        (q.size() == 0));
        check({tag, ".redirect"},    bif.redirect,     e_redirect);
        check({tag, ".redirect_pc"}, bif.redirect_pc,  e_rpc);
        check({tag, ".train_br"},    bif.train_branch, e_tb);
        if (e_tb) check({tag, ".train_res"}, bif.train_result, e_tr);
        check({tag, ".overflow"},    bif.overflow,     e_ovf);
        check({tag, ".underflow"},   bif.underflow,    e_unf);
        check({tag, ".stat_br"},     bif.stat_branches,    e_br);
        check({tag, ".stat_mis"},    bif.stat_mispredicts, e_mis);
    endtask

    // One clock: drive inputs, advance the model, clock, then compare.
    task automatic cycle(input bit p, input bit jal, input bit pr,
                         input logic [31:0] pt, input logic [31:0] pft,
                         input bit r, input bit rt, input logic [31:0] rtg,
                         input string tag);
        pred_t h;
        bit    mis;
        bif.push             = p;
        bif.push_is_jal      = jal;
        bif.push_predict     = pr;
        bif.push_target      = pt;
        bif.push_fallthrough = pft;
        bif.resolve          = r;
        bif.resolve_taken    = rt;
        bif.resolve_target   = rtg;

        mis  = 1'b0;
        e_tb = 1'b0;
        if (r && q.size() == 0) e_unf = 1'b1;
        if (r && q.size() > 0) begin
            h = q.pop_front();
            if (h.predict != rt) mis = 1'b1;
            if (h.predict && rt && h.target != rtg) mis = 1'b1;
            if (!h.is_jal) begin
                e_tb = 1'b1;
                e_tr = rt;
                e_br = e_br + 1;
            end
            if (mis) begin
                e_rpc = rt ? rtg : h.ft;
                e_mis = e_mis + 1;
            end
        end
        e_redirect = mis;
        if (mis) begin
            q.delete();
        end else if (p) begin
            if (q.size() < DEPTH) q.push_back('{jal, pr, pt, pft});
            else                  e_ovf = 1'b1;
        end

        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic do_push(input bit jal, input bit pr, input logic [31:0] pt,
                           input logic [31:0] pft, input string tag);
        cycle(1, jal, pr, pt, pft, 0, 0, 0, tag);
    endtask

    task automatic do_resolve(input bit rt, input logic [31:0] rtg, input string tag);
        cycle(0, 0, 0, 0, 0, 1, rt, rtg, tag);
    endtask

    // Resolve the current head exactly as it was predicted.
    task automatic resolve_correct(input string tag);
        pred_t h;
        h = q[0];
        do_resolve(h.predict, h.target, tag);
    endtask

    initial begin
        logic [31:0] tsel [3];
        tsel[0] = 32'h100;
        tsel[1] = 32'h104;
        tsel[2] = 32'h200;

        bif.push = 0; bif.push_is_jal = 0; bif.push_predict = 0;
        bif.push_target = 0; bif.push_fallthrough = 0;
        bif.resolve = 0; bif.resolve_taken = 0; bif.resolve_target = 0;
        model_reset();
        #2;
        check_all("reset_held");
        #10 rst = 1'b1;
        check_all("reset_released");

        // Correctly predicted taken branch.
        do_push(0, 1, 32'h100, 32'h24, "t1_push");
        do_resolve(1, 32'h100, "t1_resolve");
        idle("t1_idle");

        // Not-taken prediction, actually taken.
        do_push(0, 0, 32'h0, 32'h48, "t2a_push");
        do_resolve(1, 32'h200, "t2a_resolve");
        idle("t2a_idle");
        // Taken prediction, actually not taken: fall through.
        do_push(0, 1, 32'h80, 32'h10, "t2b_push");
        do_resolve(0, 32'h0, "t2b_resolve");
        idle("t2b_idle");

        // Mispredict with a same-cycle push flushes everything.
        for (int i = 0; i < 3; i++) do_push(0, 1, 32'h400 + 32'(i*16), 32'h500 + 32'(i*4), "t4_fill");
        cycle(1, 0, 1, 32'h900, 32'h904, 1, 1, 32'h444, "t4_mis_push");
        idle("t4_after");
        // Same with a full queue: the dropped push is not an overflow.
        for (int i = 0; i < 4; i++) do_push(0, 0, 32'h0, 32'h600 + 32'(i*4), "t4f_fill");
        cycle(1, 0, 1, 32'h910, 32'h914, 1, 1, 32'h700, "t4f_mis_push");
        idle("t4f_after");

        // JAL: correct target, then wrong target.
        do_push(1, 1, 32'h300, 32'h30, "t5_push_a");
        do_resolve(1, 32'h300, "t5_resolve_ok");
        do_push(1, 1, 32'h300, 32'h30, "t5_push_b");
        do_resolve(1, 32'h304, "t5_resolve_bad");
        idle("t5_idle");

        // Fill, overflow, in-order drain, wrap on a second fill.
        do_push(0, 0, 32'h0, 32'h1f0, "t3_offset_push");
        resolve_correct("t3_offset_pop");
        for (int i = 0; i < 4; i++)
            do_push(0, (i != 1), 32'h1000 + 32'(i*4), 32'h2000 + 32'(i*4), "t3_fill");
        do_push(0, 1, 32'hdead, 32'hbeef, "t3_overflow_push");
        for (int i = 0; i < 4; i++) resolve_correct("t3_drain");
        idle("t3_empty");
        for (int i = 0; i < 4; i++)
            do_push(0, i[0], 32'h3000 + 32'(i*4), 32'h4000 + 32'(i*4), "t3_refill");
        // Full queue: correct resolve plus push, both take effect.
        cycle(1, 0, 1, 32'h3100, 32'h4100, 1, q[0].predict, q[0].target, "t3_full_push_pop");
        while (q.size() > 0) resolve_correct("t3_drain2");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            bit          p;
            bit          pr;
            bit          r;
            bit          rt;
            logic [31:0] rtg;
            p   = ($urandom_range(0, 2) != 0);
            pr  = $urandom_range(0, 1);
            r   = ($urandom_range(0, 2) != 0);
            rt  = $urandom_range(0, 1);
            rtg = tsel[$urandom_range(0, 2)];
            if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                rt  = q[0].predict;
                rtg = q[0].target;
            end
            cycle(p, ($urandom_range(0, 4) == 0), pr, tsel[$urandom_range(0, 2)],
                  32'h800 + 32'(n*4), r, rt, rtg, "rand");
        end

        // Underflow, then asynchronous reset with entries queued.
        while (q.size() > 0) resolve_correct("t6_drain");
        do_resolve(1, 32'h100, "t6_underflow");
        do_push(0, 1, 32'h100, 32'h24, "t6_push_a");
        do_push(0, 0, 32'h0, 32'h28, "t6_push_b");
        @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_all("t6_async_reset");
        #3 rst = 1'b1;
        #1;
        do_push(0, 1, 32'h100, 32'h24, "t6_post_push");
        do_resolve(1, 32'h100, "t6_post_resolve");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
